// File: rtl/uart_cmd_parser.sv
// Framed command parser: 55 AA ADDR LEN DATA[LEN] CHK -> burst of register writes.
// Define UART_CMD_TIMEOUT_EN to build the inter-byte timeout (Err_code=3).
module uart_cmd_parser #(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Rx_byte,
   input  logic       Rx_done,
   output logic       Wr_en,
   output logic [7:0] Wr_addr,
   output logic [7:0] Wr_data,
   output logic       Frame_ok,
   output logic       Frame_err,
   output logic [1:0] Err_code,
   output logic       Rx_drop,
   output logic       Busy
);
   localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR2, S_ADDR, S_LEN, S_DATA, S_CHK, S_EMIT
   } state_t;

   state_t     state;
   logic [7:0] addr, len, idx, sum;
   logic [7:0] pay_buf [0:(1<<IW)-1];
   logic       tmo;

   assign Busy = (state != S_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
   localparam int            TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_TOP = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] tcnt;
   logic          mid;

   assign mid = (state != S_IDLE) && (state != S_EMIT);
   // An arriving byte on the expiry cycle beats the timeout.
   assign tmo = mid && !Rx_done && (tcnt == TMO_TOP);

   always_ff @(posedge Clk) begin
      if (Rst || !mid || Rx_done) tcnt <= '0;
      else if (tcnt != TMO_TOP)   tcnt <= tcnt + 1'b1;
   end
`else
   // No timeout hardware; the parameter is kept so instantiations stay uniform.
   assign tmo = (TIMEOUT_CYC < 0);
`endif

   always_ff @(posedge Clk) begin
      if (Rx_done && state == S_DATA) pay_buf[idx[IW-1:0]] <= Rx_byte;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         len       <= '0;
         idx       <= '0;
         sum       <= '0;
         Wr_en     <= 1'b0;
         Wr_addr   <= '0;
         Wr_data   <= '0;
         Frame_ok  <= 1'b0;
         Frame_err <= 1'b0;
         Err_code  <= 2'd0;
         Rx_drop   <= 1'b0;
      end else begin
         Wr_en     <= 1'b0;
         Frame_ok  <= 1'b0;
         Frame_err <= 1'b0;
         Rx_drop   <= 1'b0;
         if (tmo) begin
            state     <= S_IDLE;
            Frame_err <= 1'b1;
            Err_code  <= 2'd3;
         end else if (state == S_EMIT) begin
            Rx_drop <= Rx_done;
            Wr_en   <= 1'b1;
            Wr_addr <= addr + idx;
            Wr_data <= pay_buf[idx[IW-1:0]];
            idx     <= idx + 8'd1;
            if (idx == len - 8'd1) begin
               Frame_ok <= 1'b1;
               state    <= S_IDLE;
            end
         end else if (Rx_done) begin
            case (state)
               S_IDLE: if (Rx_byte == 8'h55) state <= S_HDR2;
               S_HDR2: begin
                  if (Rx_byte == 8'hAA)      state <= S_ADDR;
                  else if (Rx_byte != 8'h55) state <= S_IDLE;
               end
               S_ADDR: begin
                  addr  <= Rx_byte;
                  sum   <= Rx_byte;
                  state <= S_LEN;
               end
               S_LEN: begin
                  if (Rx_byte == 8'd0 || Rx_byte > MAX_LEN_B) begin
                     state     <= S_IDLE;
                     Frame_err <= 1'b1;
                     Err_code  <= 2'd1;
                  end else begin
                     len   <= Rx_byte;
                     sum   <= sum + Rx_byte;
                     idx   <= '0;
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  sum <= sum + Rx_byte;
                  idx <= idx + 8'd1;
                  if (idx == len - 8'd1) state <= S_CHK;
               end
               S_CHK: begin
                  // Issue the first write straight from the checksum cycle so
                  // writes land at T+1..T+LEN after the CHK byte.
                  if (Rx_byte == sum) begin
                     Wr_en   <= 1'b1;
                     Wr_addr <= addr;
                     Wr_data <= pay_buf[0];
                     if (len == 8'd1) begin
                        Frame_ok <= 1'b1;
                        state    <= S_IDLE;
                     end else begin
                        idx   <= 8'd1;
                        state <= S_EMIT;
                     end
                  end else begin
                     state     <= S_IDLE;
                     Frame_err <= 1'b1;
                     Err_code  <= 2'd2;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus latency/drop/reset/timeout sequences.
module tb_uart_cmd_parser;
   localparam int MAX_LEN = 16;
   localparam int TMO     = 100;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] Rx_byte = 8'h00;
   logic       Rx_done = 1'b0;
   logic       Wr_en, Frame_ok, Frame_err, Rx_drop, Busy;
   logic [7:0] Wr_addr, Wr_data;
   logic [1:0] Err_code;

   uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
      .Clk(Clk), .Rst(Rst), .Rx_byte(Rx_byte), .Rx_done(Rx_done),
      .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
      .Frame_ok(Frame_ok), .Frame_err(Frame_err), .Err_code(Err_code),
      .Rx_drop(Rx_drop), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Output monitor on the falling edge.
   logic [7:0] wa_log[$];
   logic [7:0] wd_log[$];
   int n_ok = 0, n_errp = 0, n_drop = 0, n_both = 0, ok_bad = 0;
   always @(negedge Clk) begin
      if (Wr_en) begin
         wa_log.push_back(Wr_addr);
         wd_log.push_back(Wr_data);
      end
      if (Frame_ok) begin
         n_ok++;
         if (!Wr_en) ok_bad++;
      end
      if (Frame_err) n_errp++;
      if (Rx_drop) n_drop++;
      if (Frame_ok && Frame_err) n_both++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge Clk); #1;
      Rx_byte = b;
      Rx_done = 1'b1;
      @(posedge Clk); #1;
      Rx_done = 1'b0;
   endtask

   task automatic run_frame(input logic [191:0] b, input int nb);
      for (int k = 0; k < nb; k++) send_byte(b[8*(nb-1-k) +: 8]);
   endtask

   typedef struct {
      logic [191:0] b;
      int           nb;
      int           nw;
      logic [127:0] wa;
      logic [127:0] wd;
      int           ok;
      int           err;
      logic [1:0]   code;
   } vec_t;

   vec_t tv [8];
   int   w0, ok0, er0, dr0;

   initial begin
      tv[0] = '{64'h55AA100311223379, 8, 3, 24'h101112, 24'h112233, 1, 0, 2'd0};
      tv[1] = '{64'h55AA100311223378, 8, 0, 0, 0, 0, 1, 2'd2};
      tv[2] = '{32'h55AA0000, 4, 0, 0, 0, 0, 1, 2'd1};
      tv[3] = '{32'h55AA1011, 4, 0, 0, 0, 0, 1, 2'd1};
      tv[4] = '{56'h5555AA20015A7B, 7, 1, 8'h20, 8'h5A, 1, 0, 2'd1};
      tv[5] = '{56'h55AAFF02010204, 7, 2, 16'hFF00, 16'h0102, 1, 0, 2'd1};
      tv[6] = '{72'h13553355AA0501A7AD, 9, 1, 8'h05, 8'hA7, 1, 0, 2'd1};
      tv[7] = '{168'h55AA4010_0102030405060708090A0B0C0D0E0F10_D8, 21, 16,
                128'h404142434445464748494A4B4C4D4E4F,
                128'h0102030405060708090A0B0C0D0E0F10, 1, 0, 2'd1};

      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      chk("rst Wr_en", Wr_en, 0);
      chk("rst Frame_ok", Frame_ok, 0);
      chk("rst Frame_err", Frame_err, 0);
      chk("rst Err_code", Err_code, 0);
      chk("rst Rx_drop", Rx_drop, 0);
      chk("rst Busy", Busy, 0);

      for (int v = 0; v < 8; v++) begin
         w0 = wa_log.size(); ok0 = n_ok; er0 = n_errp;
         run_frame(tv[v].b, tv[v].nb);
         repeat (20) @(posedge Clk);
         #1;
         chk($sformatf("v%0d nwr", v), wa_log.size() - w0, tv[v].nw);
         if (wa_log.size() - w0 == tv[v].nw)
            for (int i = 0; i < tv[v].nw; i++) begin
               chk($sformatf("v%0d addr%0d", v, i), wa_log[w0+i], tv[v].wa[8*(tv[v].nw-1-i) +: 8]);
               chk($sformatf("v%0d data%0d", v, i), wd_log[w0+i], tv[v].wd[8*(tv[v].nw-1-i) +: 8]);
            end
         chk($sformatf("v%0d ok", v), n_ok - ok0, tv[v].ok);
         chk($sformatf("v%0d err", v), n_errp - er0, tv[v].err);
         chk($sformatf("v%0d code", v), Err_code, tv[v].code);
         chk($sformatf("v%0d busy", v), Busy, 0);
      end

      // Exact latency plus a 0x55 injected mid-EMIT.
      dr0 = n_drop;
      run_frame(tv[0].b, 8);
      chk("lat first wr", {Wr_en, Wr_addr, Wr_data}, {1'b1, 8'h10, 8'h11});
      Rx_byte = 8'h55; Rx_done = 1'b1;
      @(posedge Clk); #1 Rx_done = 1'b0;
      chk("drop pulse", Rx_drop, 1);
      chk("lat second wr", {Wr_en, Wr_addr, Wr_data}, {1'b1, 8'h11, 8'h22});
      @(posedge Clk); #1;
      chk("lat third wr+ok", {Wr_en, Wr_addr, Wr_data, Frame_ok}, {1'b1, 8'h12, 8'h33, 1'b1});
      chk("drop once", n_drop - dr0, 1);
      @(posedge Clk); #1;
      chk("post emit wr", Wr_en, 0);
      chk("55 ignored busy", Busy, 0);

      // Reset mid-frame, then a clean frame.
      run_frame(64'h55AA100311, 5);
      Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
      chk("rstmid outs", {Wr_en, Frame_ok, Frame_err, Err_code, Rx_drop, Busy}, 0);
      w0 = wa_log.size(); ok0 = n_ok;
      run_frame(tv[0].b, 8);
      repeat (6) @(posedge Clk);
      #1;
      chk("rstmid nwr", wa_log.size() - w0, 3);
      if (wa_log.size() - w0 == 3) chk("rstmid last", {wa_log[w0+2], wd_log[w0+2]}, 16'h1233);
      chk("rstmid ok", n_ok - ok0, 1);

      // Reset during EMIT stops the burst.
      w0 = wa_log.size(); ok0 = n_ok;
      run_frame(tv[0].b, 8);
      Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      chk("rstemit nwr", wa_log.size() - w0, 1);
      chk("rstemit ok", n_ok - ok0, 0);
      chk("rstemit busy", Busy, 0);

`ifdef UART_CMD_TIMEOUT_EN
      // Byte arriving exactly on the expiry cycle wins.
      w0 = wa_log.size(); ok0 = n_ok; er0 = n_errp;
      run_frame(24'h55AA10, 3);
      repeat (98) @(posedge Clk);
      run_frame(24'h015A6B, 3);
      repeat (5) @(posedge Clk);
      #1;
      chk("tmo race err", n_errp - er0, 0);
      chk("tmo race ok", n_ok - ok0, 1);
      chk("tmo race nwr", wa_log.size() - w0, 1);
      if (wa_log.size() - w0 == 1) chk("tmo race wr", {wa_log[w0], wd_log[w0]}, 16'h105A);

      er0 = n_errp;
      run_frame(24'h55AA10, 3);
      repeat (90) @(posedge Clk);
      #1;
      chk("tmo early busy", Busy, 1);
      chk("tmo early err", n_errp - er0, 0);
      repeat (15) @(posedge Clk);
      #1;
      chk("tmo err", n_errp - er0, 1);
      chk("tmo code", Err_code, 3);
      chk("tmo busy", Busy, 0);
`else
      // Without the timeout the parser waits indefinitely.
      er0 = n_errp;
      run_frame(24'h55AA10, 3);
      repeat (300) @(posedge Clk);
      #1;
      chk("stall busy", Busy, 1);
      chk("stall err", n_errp - er0, 0);
      chk("stall code", Err_code, 0);
      Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
`endif

      w0 = wa_log.size(); ok0 = n_ok;
      run_frame(tv[4].b, 7);
      repeat (5) @(posedge Clk);
      #1;
      chk("after nwr", wa_log.size() - w0, 1);
      chk("after ok", n_ok - ok0, 1);

      chk("ok without wr", ok_bad, 0);
      chk("ok and err", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
